ofdm_symbol_scheduler: RTL and testbench

OFDM_SYMBOL_SCHEDULER -- requirements
Module: ofdm_symbol_scheduler

---
 rtl/ofdm_pkg.sv | 36 +++
 rtl/ofdm_axis_out_reg.sv | 62 ++++++
 rtl/ofdm_symbol_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_ofdm_symbol_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_pkg
// Description : Shared OFDM transmit-chain constants: subcarrier count, word
//               and counter widths, mapper/IFFT sizing and the symbol
//               scheduler state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package ofdm_pkg;

  // The IFFT size sets the number of subcarriers per OFDM symbol.
  localparam int unsigned C_IFFT_LEN   = 8;
  localparam int unsigned C_N_SC       = C_IFFT_LEN;

  // Word width presented to the QAM mapper.
  localparam int unsigned C_MAP_WORD_W = 8;
  localparam int unsigned C_WORD_W     = C_MAP_WORD_W;

  // Counter widths used by the scheduler.
  localparam int unsigned C_SYM_CNT_W  = 4;   // symbol index within a frame
  localparam int unsigned C_GAP_CNT_W  = 8;   // inter-frame gap, up to 256 cycles

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GAP      = 2'd3
  } sched_state_e;

  // Width of an index counter covering 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ofdm_axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_axis_out_reg
// Description : Single-register valid/ready output stage. Loads a new word
//               whenever the register is empty or being drained this cycle,
//               and holds data/last/sof stable while the sink stalls.
// Ports       : i_clk, i_rst_n      clock, synchronous active-low reset
//               i_push, i_data,
//               i_last, i_sof       word offered by the scheduler
//               o_load              register can accept a word this cycle
//               o_data, o_valid,
//               o_last, o_sof,
//               i_ready             stream side towards the mapper
// Revision    : 1.0  initial release
// ============================================================================
module ofdm_axis_out_reg
  import ofdm_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic [C_WORD_W-1:0] i_data,
  input  logic                i_last,
  input  logic                i_sof,
  output logic                o_load,
  output logic [C_WORD_W-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last,
  output logic                o_sof
);

  logic                r_valid;
  logic [C_WORD_W-1:0] r_data;
  logic                r_last;
  logic                r_sof;

  assign o_load  = !r_valid || i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_last  = r_last;
  assign o_sof   = r_sof;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_sof   <= 1'b0;
    end else if (o_load) begin
      r_valid <= i_push;
      // Payload only changes when a real word arrives.
      if (i_push) begin
        r_data <= i_data;
        r_last <= i_last;
        r_sof  <= i_sof;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ofdm_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_symbol_scheduler
// Description : Builds OFDM frames (preamble symbols, data symbols, idle gap)
//               as a word stream for the QAM mapper. Data words come from the
//               generator on active carriers and are zero on masked ones.
// Ports       : aclk, aresetn       clock, synchronous active-low reset
//               enable              frame generation enable
//               carrier_control     requested subcarrier mask
//               s_data/valid/ready  generator stream in
//               m_data/valid/ready,
//               m_last, m_sof       mapper stream out
//               active_mask         mask in force for the current symbol
//               sym_count           symbol index within the frame
//               frame_busy          high outside IDLE
// Revision    : 1.0  initial release
// ============================================================================
module ofdm_symbol_scheduler
  import ofdm_pkg::*;
#(
  parameter int unsigned          N_SC      = C_N_SC,
  parameter int unsigned          PRE_SYMS  = 2,
  parameter int unsigned          DATA_SYMS = 8,
  parameter int unsigned          GAP_CYC   = 16,
  parameter logic [C_WORD_W-1:0]  PRE_WORD  = 8'hA5
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic [N_SC-1:0]        carrier_control,
  input  logic [C_WORD_W-1:0]    s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [C_WORD_W-1:0]    m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   m_sof,
  output logic [N_SC-1:0]        active_mask,
  output logic [C_SYM_CNT_W-1:0] sym_count,
  output logic                   frame_busy
);

  localparam int unsigned             K_W       = cnt_width(N_SC);
  localparam logic [K_W-1:0]          K_LAST    = K_W'(N_SC - 1);
  localparam logic [C_SYM_CNT_W-1:0]  PRE_LAST  = C_SYM_CNT_W'(PRE_SYMS - 1);
  localparam logic [C_SYM_CNT_W-1:0]  DATA_LAST = C_SYM_CNT_W'(DATA_SYMS - 1);
  localparam logic [C_SYM_CNT_W-1:0]  SYM_LAST  = C_SYM_CNT_W'(PRE_SYMS + DATA_SYMS - 1);
  localparam logic [C_GAP_CNT_W-1:0]  GAP_LAST  = C_GAP_CNT_W'(GAP_CYC - 1);

  sched_state_e           r_state;
  logic [K_W-1:0]         r_k;            // carrier index of the next word to load
  logic [C_SYM_CNT_W-1:0] r_ld_sym;       // symbol index within PREAMBLE or DATA, load side
  logic [C_SYM_CNT_W-1:0] r_sym_count;    // symbol index, transfer side
  logic [C_GAP_CNT_W-1:0] r_gap;
  logic                   r_ld_done;      // last data word loaded, waiting for it to drain
  logic [N_SC-1:0]        r_active_mask;

  logic                   w_load;
  logic                   w_in_data;
  logic                   w_k_last;
  logic                   w_mask_bit;
  logic                   w_word_avail;
  logic                   w_fire;
  logic                   w_xfer;
  logic                   w_sof;
  logic [C_WORD_W-1:0]    w_word;

  assign w_k_last  = (r_k == K_LAST);
  assign w_in_data = (r_state == ST_DATA) && !r_ld_done;
  // Word k=0 is the one that latches the mask, so it must already obey the
  // fresh carrier_control value rather than the previous symbol's mask.
  assign w_mask_bit = (r_k == '0) ? carrier_control[r_k] : r_active_mask[r_k];

  // Masked carriers never wait for the generator; active ones need s_valid.
  assign w_word_avail = (r_state == ST_PREAMBLE) ||
                        (w_in_data && (!w_mask_bit || s_valid));
  assign w_fire  = w_word_avail && w_load;
  assign s_ready = w_in_data && w_mask_bit && w_load;
  assign w_xfer  = m_valid && m_ready;
  assign w_sof   = (r_state == ST_PREAMBLE) && (r_ld_sym == '0) && (r_k == '0);

  always_comb begin
    w_word = '0;
    if (r_state == ST_PREAMBLE) begin
      w_word = PRE_WORD;
    end else if (w_mask_bit) begin
      w_word = s_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state       <= ST_IDLE;
      r_k           <= '0;
      r_ld_sym      <= '0;
      r_sym_count   <= '0;
      r_gap         <= '0;
      r_ld_done     <= 1'b0;
      r_active_mask <= '0;
    end else begin
      if (w_xfer && m_last) begin
        r_sym_count <= (r_sym_count == SYM_LAST) ? '0 : r_sym_count + 1'b1;
      end

      if (w_fire) begin
        if (r_k == '0) begin
          r_active_mask <= carrier_control;
        end
        if (w_k_last) begin
          r_k      <= '0;
          r_ld_sym <= r_ld_sym + 1'b1;
        end else begin
          r_k <= r_k + 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state     <= ST_PREAMBLE;
            r_k         <= '0;
            r_ld_sym    <= '0;
            r_sym_count <= '0;
          end
        end
        ST_PREAMBLE: begin
          // Switch on the load of the final preamble word so the very next
          // load is data word k=0 with no bubble.
          if (w_fire && w_k_last && (r_ld_sym == PRE_LAST)) begin
            r_state  <= ST_DATA;
            r_ld_sym <= '0;
          end
        end
        ST_DATA: begin
          if (w_fire && w_k_last && (r_ld_sym == DATA_LAST)) begin
            r_ld_done <= 1'b1;
          end
          // Leave only once the final word has left the output register, so
          // m_valid is already low throughout GAP.
          if (r_ld_done && w_xfer) begin
            r_state   <= ST_GAP;
            r_ld_done <= 1'b0;
            r_gap     <= '0;
          end
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_gap       <= '0;
            r_state     <= enable ? ST_PREAMBLE : ST_IDLE;
            r_k         <= '0;
            r_ld_sym    <= '0;
            r_sym_count <= '0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign active_mask = r_active_mask;
  assign sym_count   = r_sym_count;
  assign frame_busy  = (r_state != ST_IDLE);

  ofdm_axis_out_reg u_out_reg (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_push  (w_fire),
    .i_data  (w_word),
    .i_last  (w_k_last),
    .i_sof   (w_sof),
    .o_load  (w_load),
    .o_data  (m_data),
    .o_valid (m_valid),
    .i_ready (m_ready),
    .o_last  (m_last),
    .o_sof   (m_sof)
  );

endmodule
`default_nettype wire

// File: tb/tb_ofdm_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofdm_symbol_scheduler
// Description : Self-checking bench for ofdm_symbol_scheduler. A frame-level
//               model predicts every transferred word from its position in
//               the frame, the per-symbol mask and the generator order.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ofdm_symbol_scheduler;

  localparam int          N_SC        = 8;
  localparam int          PRE_SYMS    = 2;
  localparam int          DATA_SYMS   = 8;
  localparam int          GAP_CYC     = 16;
  localparam int          FRAME_WORDS = (PRE_SYMS + DATA_SYMS) * N_SC;
  localparam logic [7:0]  PRE_WORD    = 8'hA5;

  logic            clk = 1'b0;
  logic            aresetn;
  logic            enable;
  logic [N_SC-1:0] cc;
  logic [7:0]      s_data;
  logic            s_valid;
  logic            s_ready;
  logic [7:0]      m_data;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic            m_last;
  logic            m_sof;
  logic [N_SC-1:0] active_mask;
  logic [3:0]      sym_count;
  logic            frame_busy;

  always #5 clk = ~clk;

  ofdm_symbol_scheduler #(
    .N_SC(N_SC), .PRE_SYMS(PRE_SYMS), .DATA_SYMS(DATA_SYMS),
    .GAP_CYC(GAP_CYC), .PRE_WORD(PRE_WORD)
  ) dut (
    .aclk(clk), .aresetn(aresetn), .enable(enable), .carrier_control(cc),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_sof(m_sof), .active_mask(active_mask),
    .sym_count(sym_count), .frame_busy(frame_busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- generator and sink drivers ----------------
  int  gen_cnt         = 0;   // number of generator words consumed
  bit  consume_pending = 0;   // handshake seen before the coming edge
  bit  throttle        = 0;

  always @(posedge clk) begin
    #1;
    if (consume_pending) gen_cnt++;
    s_valid = throttle ? ($urandom_range(9) < 7) : 1'b1;
    s_data  = s_valid ? gen_cnt[7:0] : 8'hEE;
    m_ready = throttle ? 1'($urandom_range(1)) : 1'b1;
  end

  // ---------------- frame model and compare process ----------------
  logic [N_SC-1:0] exp_mask [DATA_SYMS];
  logic [7:0]      log_data [FRAME_WORDS];
  logic [7:0]      model_gen     = 8'h00;   // next generator value expected out
  int              m_idx         = 0;       // transfers so far in this frame
  int              frames_done   = 0;
  int              cyc           = 0;
  int              last_xfer_cyc = 0;
  int              last_gap      = -1;
  int              sready_hi     = 0;
  int              xfers         = 0;
  bit              have_prev     = 0;
  bit              stall_prev    = 0;
  logic [7:0]      p_data;
  logic            p_last, p_sof;

  always @(negedge clk) begin
    int         sym, k;
    logic [7:0] ed;
    logic       el, es;
    cyc++;
    if (!aresetn) begin
      m_idx           = 0;
      stall_prev      = 0;
      consume_pending = 0;
      have_prev       = 0;
    end else begin
      consume_pending = s_valid && s_ready;
      if (s_ready) sready_hi++;
      if (!frame_busy) begin
        have_prev = 0;
        chk(!m_valid && !s_ready, "idle_quiet", {m_valid, s_ready}, 0);
      end
      if (stall_prev)
        chk(m_valid && m_data == p_data && m_last == p_last && m_sof == p_sof,
            "stall_hold", {m_valid, m_last, m_sof, m_data}, {1'b1, p_last, p_sof, p_data});
      if (m_valid && m_ready) begin
        sym = m_idx / N_SC;
        k   = m_idx % N_SC;
        if (sym < PRE_SYMS) begin
          ed = PRE_WORD;
        end else if (exp_mask[sym - PRE_SYMS][k]) begin
          ed = model_gen;
          model_gen++;
        end else begin
          ed = 8'h00;
        end
        el = (k == N_SC - 1);
        es = (m_idx == 0);
        chk(m_data == ed && m_last == el && m_sof == es && sym_count == 4'(sym),
            "xfer_word", {sym_count, m_last, m_sof, m_data}, {4'(sym), el, es, ed});
        log_data[m_idx] = m_data;
        if (m_idx == 0 && have_prev) last_gap = cyc - last_xfer_cyc - 1;
        xfers++;
        m_idx++;
        if (m_idx == FRAME_WORDS) begin
          m_idx         = 0;
          frames_done++;
          last_xfer_cyc = cyc;
          have_prev     = 1;
        end
      end
      stall_prev = m_valid && !m_ready;
      p_data     = m_data;
      p_last     = m_last;
      p_sof      = m_sof;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mask_all(input logic [N_SC-1:0] m);
    for (int i = 0; i < DATA_SYMS; i++) exp_mask[i] = m;
  endtask

  task automatic wait_frames(input int n);
    int tgt;
    tgt = frames_done + n;
    for (int i = 0; i < 4000; i++) begin
      if (frames_done >= tgt) break;
      step();
    end
    chk(frames_done >= tgt, "frame_timeout", frames_done, tgt);
  endtask

  task automatic wait_idx(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (m_idx == target) break;
      step();
    end
    chk(m_idx == target, "idx_timeout", m_idx, target);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (!frame_busy) break;
      step();
      cycles++;
    end
    chk(!frame_busy, "idle_timeout", frame_busy, 0);
  endtask

  task automatic check_reset(input string tag);
    chk(!m_valid && !m_last && !m_sof && !s_ready && !frame_busy,
        {tag, "_ctl"}, {m_valid, m_last, m_sof, s_ready, frame_busy}, 0);
    chk(m_data == 8'h00, {tag, "_data"}, m_data, 0);
    chk(active_mask == '0 && sym_count == 4'd0, {tag, "_cnt"}, {active_mask, sym_count}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int g0, x0, s0, cyc_idle, f0;
    aresetn = 1'b0;
    enable  = 1'b0;
    cc      = 8'hFE;
    set_mask_all(8'hFE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    step();
    aresetn = 1'b1;
    repeat (4) step();
    chk(!frame_busy, "idle_no_enable", frame_busy, 0);

    // Two back-to-back frames, mask FE, counting data, full rate.
    g0 = gen_cnt;
    enable = 1'b1;
    wait_frames(1);
    chk(log_data[0]  == 8'hA5, "pre_w0",  log_data[0],  8'hA5);
    chk(log_data[15] == 8'hA5, "pre_w15", log_data[15], 8'hA5);
    chk(log_data[16] == 8'h00, "d0_k0",   log_data[16], 8'h00);
    chk(log_data[17] == 8'h00, "d0_k1",   log_data[17], 8'h00);
    chk(log_data[18] == 8'h01, "d0_k2",   log_data[18], 8'h01);
    chk(log_data[23] == 8'h06, "d0_k7",   log_data[23], 8'h06);
    chk(log_data[25] == 8'h07, "d1_k1",   log_data[25], 8'h07);
    chk(log_data[31] == 8'h0D, "d1_k7",   log_data[31], 8'h0D);
    chk(log_data[79] == 8'h37, "d7_k7",   log_data[79], 8'h37);
    chk(gen_cnt - g0 == 56, "consumed_fe", gen_cnt - g0, 56);
    wait_frames(1);
    enable = 1'b0;
    chk(last_gap >= GAP_CYC && last_gap <= GAP_CYC + 2, "gap_len", last_gap, GAP_CYC);
    wait_idle(cyc_idle);

    // Throttled sink and bursty generator.
    g0 = gen_cnt;
    throttle = 1'b1;
    enable = 1'b1;
    wait_frames(1);
    enable = 1'b0;
    throttle = 1'b0;
    wait_idle(cyc_idle);
    chk(gen_cnt - g0 == 56, "consumed_thr", gen_cnt - g0, 56);

    // Mask change FE -> 0F in the middle of data symbol 0.
    set_mask_all(8'h0F);
    exp_mask[0] = 8'hFE;
    cc = 8'hFE;
    g0 = gen_cnt;
    enable = 1'b1;
    wait_idx(PRE_SYMS * N_SC + 3);
    cc = 8'h0F;
    wait_frames(1);
    enable = 1'b0;
    chk(log_data[16] == 8'h00,      "m_d0_k0", log_data[16], 8'h00);
    chk(log_data[17] == 8'(g0),     "m_d0_k1", log_data[17], 8'(g0));
    chk(log_data[24] == 8'(g0 + 7), "m_d1_k0", log_data[24], 8'(g0 + 7));
    chk(log_data[27] == 8'(g0 + 10),"m_d1_k3", log_data[27], 8'(g0 + 10));
    chk(log_data[28] == 8'h00,      "m_d1_k4", log_data[28], 8'h00);
    chk(gen_cnt - g0 == 35, "consumed_0f", gen_cnt - g0, 35);
    wait_idle(cyc_idle);

    // All-zero mask: zero data symbols, no generator traffic, full length.
    cc = 8'h00;
    set_mask_all(8'h00);
    g0 = gen_cnt;
    x0 = xfers;
    s0 = sready_hi;
    enable = 1'b1;
    wait_frames(1);
    enable = 1'b0;
    chk(sready_hi == s0, "zero_sready", sready_hi - s0, 0);
    chk(gen_cnt == g0, "zero_consumed", gen_cnt - g0, 0);
    chk(xfers - x0 == FRAME_WORDS, "zero_len", xfers - x0, FRAME_WORDS);
    wait_idle(cyc_idle);

    // enable dropped during data symbol 3: frame and gap complete, then IDLE.
    cc = 8'hFE;
    set_mask_all(8'hFE);
    enable = 1'b1;
    wait_idx((PRE_SYMS + 3) * N_SC + 2);
    enable = 1'b0;
    wait_frames(1);
    chk(frame_busy, "busy_in_gap", frame_busy, 1);
    wait_idle(cyc_idle);
    chk(cyc_idle >= GAP_CYC - 1 && cyc_idle <= GAP_CYC + 1, "gap_to_idle", cyc_idle, GAP_CYC);
    f0 = frames_done;
    repeat (5) step();
    chk(!frame_busy && frames_done == f0, "stay_idle", {frame_busy, 8'(frames_done - f0)}, 0);
    enable = 1'b1;
    wait_frames(1);
    enable = 1'b0;
    wait_idle(cyc_idle);

    // Reset pulse during preamble word 5, then a clean new frame.
    g0 = gen_cnt;
    enable = 1'b1;
    wait_idx(5);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    f0 = frames_done;
    wait_frames(1);
    enable = 1'b0;
    chk(frames_done == f0 + 1 && gen_cnt - g0 == 56, "post_rst_frame",
        gen_cnt - g0, 56);
    wait_idle(cyc_idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
